uncached_write_buffer: RTL and testbench

Parametrised posted-write buffer for the uncached data path, between the CPU's uncached dbus signals (read/write/stall/rddata) and the uncached memory port. Uncached writes are accepted in one cycle and drained in order. Optional write-combining merges consecutive writes to the same word. Uncached reads are strictly ordered after every buffered write, then issued to memory.

---
 rtl/uncached_write_buffer_pkg.sv | 35 +++
 rtl/uncached_write_buffer.sv | 142 ++++++++++++++
 tb/tb_uncached_write_buffer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uncached_write_buffer_pkg.sv
// Shared definitions for the uncached write buffer: entry layout, FSM states
// and the byte-lane merge helper used by write-combining.
package uncached_write_buffer_pkg;

    localparam int unsigned UWB_ADDR_WIDTH = 32;
    localparam int unsigned UWB_DATA_WIDTH = 32;
    localparam int unsigned UWB_BE_WIDTH   = UWB_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } uncached_wbuf_state_t;

    typedef struct packed {
        logic [UWB_ADDR_WIDTH-1:0] addr;
        logic [UWB_DATA_WIDTH-1:0] data;
        logic [UWB_BE_WIDTH-1:0]   be;
    } uncached_wbuf_entry_t;

    // Overwrite only the byte lanes selected by be.
    function automatic logic [UWB_DATA_WIDTH-1:0] merge_bytes(
        input logic [UWB_DATA_WIDTH-1:0] old_data,
        input logic [UWB_DATA_WIDTH-1:0] new_data,
        input logic [UWB_BE_WIDTH-1:0]   be
    );
        logic [UWB_DATA_WIDTH-1:0] res;
        res = old_data;
        for (int i = 0; i < int'(UWB_BE_WIDTH); i++) begin
            if (be[i]) res[8*i +: 8] = new_data[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/uncached_write_buffer.sv
// Posted-write buffer for the uncached data path: in-order write drain with
// optional tail write-combining; reads are issued only once all writes drain.
module uncached_write_buffer
    import uncached_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          MERGE_EN   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_uncached_write,
    input  logic                    cpu_uncached_read,
    input  logic [ADDR_WIDTH-1:0]   cpu_address,
    input  logic [DATA_WIDTH-1:0]   cpu_wrdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_byteenable,
    output logic                    cpu_uncached_stall,
    output logic [DATA_WIDTH-1:0]   cpu_uncached_rddata,
    output logic                    mem_write,
    output logic                    mem_read,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_wrdata,
    output logic [DATA_WIDTH/8-1:0] mem_byteenable,
    input  logic                    mem_stall,
    input  logic [DATA_WIDTH-1:0]   mem_rddata,
    output logic                    wbuf_empty
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned OFFS_W   = $clog2(BE_WIDTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Entry layout comes from the shared bus header, so widths must agree with it.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_WIDTH != UWB_ADDR_WIDTH ||
        DATA_WIDTH != UWB_DATA_WIDTH || (DATA_WIDTH % 8) != 0) begin : g_param_err
        $error("uncached_write_buffer: unsupported parameter set");
    end

    uncached_wbuf_state_t state_q, state_d;
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d, last_idx;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    uncached_wbuf_entry_t  entry_q [DEPTH];
    logic                  merge_hit, wr_ok, push, merge, pop;

    always_comb begin
        state_d            = state_q;
        head_d             = head_q;
        tail_d             = tail_q;
        count_d            = count_q;
        rd_addr_d          = rd_addr_q;
        rd_data_d          = rd_data_q;
        pop                = 1'b0;
        mem_write          = 1'b0;
        mem_read           = 1'b0;
        mem_address        = entry_q[head_q].addr;
        mem_wrdata         = entry_q[head_q].data;
        mem_byteenable     = entry_q[head_q].be;
        cpu_uncached_stall = 1'b0;

        last_idx  = tail_q - PTR_W'(1);
        merge_hit = MERGE_EN && (count_q >= CNT_W'(2)) &&
                    (cpu_address[ADDR_WIDTH-1:OFFS_W] ==
                     entry_q[last_idx].addr[ADDR_WIDTH-1:OFFS_W]);
        // Merge targets the tail, never the head, so it is legal even when full.
        wr_ok = !rst && ((count_q < DEPTH_C) || merge_hit);
        push  = cpu_uncached_write && wr_ok && !merge_hit;
        merge = cpu_uncached_write && wr_ok && merge_hit;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    mem_write = 1'b1;
                    pop       = !mem_stall;
                end else if (cpu_uncached_read && !rst) begin
                    state_d   = READ;
                    rd_addr_d = cpu_address;
                end
            end
            READ: begin
                mem_read    = 1'b1;
                mem_address = rd_addr_q;
                if (!mem_stall) begin
                    rd_data_d = mem_rddata;
                    state_d   = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (cpu_uncached_write) begin
            cpu_uncached_stall = !wr_ok;
        end else if (cpu_uncached_read) begin
            cpu_uncached_stall = rst || (state_q != DONE);
        end

        if (pop)  head_d = head_q + PTR_W'(1);
        if (push) tail_d = tail_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Entry storage needs no reset: count gates every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[tail_q] <= '{addr: cpu_address, data: cpu_wrdata, be: cpu_byteenable};
        end else if (merge) begin
            entry_q[last_idx].data <= merge_bytes(entry_q[last_idx].data, cpu_wrdata,
                                                  cpu_byteenable);
            entry_q[last_idx].be   <= entry_q[last_idx].be | cpu_byteenable;
        end
    end

    assign cpu_uncached_rddata = rd_data_q;
    assign wbuf_empty          = (count_q == '0) && (state_q == IDLE);

    logic unused_be_width;
    assign unused_be_width = ^BE_WIDTH;

endmodule

// File: tb/tb_uncached_write_buffer.sv
// Randomised bench for uncached_write_buffer against a queue-based model of
// the posted-write / ordered-read behaviour, checked every cycle.
module tb_uncached_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_uncached_write, cpu_uncached_read;
    logic [31:0] cpu_address, cpu_wrdata;
    logic [3:0]  cpu_byteenable;
    logic        cpu_uncached_stall;
    logic [31:0] cpu_uncached_rddata;
    logic        mem_write, mem_read;
    logic [31:0] mem_address, mem_wrdata;
    logic [3:0]  mem_byteenable;
    logic        mem_stall;
    logic [31:0] mem_rddata;
    logic        wbuf_empty;

    uncached_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MERGE_EN(1'b1)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cpu_uncached_write  (cpu_uncached_write),
        .cpu_uncached_read   (cpu_uncached_read),
        .cpu_address         (cpu_address),
        .cpu_wrdata          (cpu_wrdata),
        .cpu_byteenable      (cpu_byteenable),
        .cpu_uncached_stall  (cpu_uncached_stall),
        .cpu_uncached_rddata (cpu_uncached_rddata),
        .mem_write           (mem_write),
        .mem_read            (mem_read),
        .mem_address         (mem_address),
        .mem_wrdata          (mem_wrdata),
        .mem_byteenable      (mem_byteenable),
        .mem_stall           (mem_stall),
        .mem_rddata          (mem_rddata),
        .wbuf_empty          (wbuf_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        assert (!(cpu_uncached_read && cpu_uncached_write)) else $error("illegal read+write request");

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } went_t;

    int n_checks = 0;
    int n_errors = 0;

    // Model: buffered writes in arrival order plus the progress of one read.
    went_t       wq[$];
    bit          rd_at_mem;
    bit          rd_returning;
    logic [31:0] rd_addr_m, rd_reg_m;

    // Expectations for the current cycle.
    bit exp_mw, exp_mr, exp_stall, hit;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        wq.delete();
        rd_at_mem    = 1'b0;
        rd_returning = 1'b0;
        rd_reg_m     = '0;
    endtask

    task automatic new_request(input int p_req);
        if ($urandom_range(0, 99) < p_req) begin
            cpu_address = 32'h1FD0_0000 + ($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 99) < 20) begin
                cpu_uncached_read = 1'b1;
            end else begin
                cpu_uncached_write = 1'b1;
                cpu_wrdata         = $urandom;
                cpu_byteenable     = 4'($urandom_range(1, 15));
            end
        end
    endtask

    task automatic compare_cycle();
        bit idle;
        idle   = !rd_at_mem && !rd_returning;
        exp_mw = idle && (wq.size() > 0);
        exp_mr = rd_at_mem;
        hit    = (wq.size() >= 2) && (wq[wq.size()-1].a[31:2] == cpu_address[31:2]);
        if (rst)                     exp_stall = cpu_uncached_write || cpu_uncached_read;
        else if (cpu_uncached_write) exp_stall = !((wq.size() < DEPTH) || hit);
        else if (cpu_uncached_read)  exp_stall = !rd_returning;
        else                         exp_stall = 1'b0;

        check("stall", 64'(cpu_uncached_stall), 64'(exp_stall));
        check("mem_write", 64'(mem_write), 64'(exp_mw));
        check("mem_read", 64'(mem_read), 64'(exp_mr));
        check("wbuf_empty", 64'(wbuf_empty), 64'(idle && wq.size() == 0));
        check("rddata", 64'(cpu_uncached_rddata), 64'(rd_reg_m));
        if (exp_mw) begin
            check("wr_addr", 64'(mem_address), 64'(wq[0].a));
            check("wr_data", 64'(mem_wrdata), 64'(wq[0].d));
            check("wr_be", 64'(mem_byteenable), 64'(wq[0].be));
        end
        if (exp_mr) check("rd_addr", 64'(mem_address), 64'(rd_addr_m));
    endtask

    // Advance the model across the coming clock edge; returns whether the
    // CPU's current request completes at that edge.
    task automatic model_step(output bit done);
        int    size_before;
        went_t e;
        done = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        size_before = wq.size();
        done = (cpu_uncached_write || cpu_uncached_read) && !exp_stall;
        if (cpu_uncached_write && done && hit) begin
            e = wq[wq.size()-1];
            for (int i = 0; i < 4; i++)
                if (cpu_byteenable[i]) e.d[8*i +: 8] = cpu_wrdata[8*i +: 8];
            e.be = e.be | cpu_byteenable;
            wq[wq.size()-1] = e;
        end
        if (exp_mw && !mem_stall) void'(wq.pop_front());
        if (cpu_uncached_write && done && !hit)
            wq.push_back('{a: cpu_address, d: cpu_wrdata, be: cpu_byteenable});
        if (rd_returning) begin
            rd_returning = 1'b0;
        end else if (rd_at_mem) begin
            if (!mem_stall) begin
                rd_reg_m     = mem_rddata;
                rd_at_mem    = 1'b0;
                rd_returning = 1'b1;
            end
        end else if (size_before == 0 && cpu_uncached_read) begin
            rd_at_mem = 1'b1;
            rd_addr_m = cpu_address;
        end
    endtask

    initial begin
        bit done;
        int p_stall, p_req, p_rst;
        rst = 1'b1;
        cpu_uncached_write = 1'b1;
        cpu_uncached_read  = 1'b0;
        cpu_address        = 32'h1FD0_0000;
        cpu_wrdata         = 32'h1234_5678;
        cpu_byteenable     = 4'hF;
        mem_stall          = 1'b0;
        mem_rddata         = 32'hDEAD_BEEF;
        model_reset();

        repeat (2) @(posedge clk);
        #2;
        check("reset_mem_write", 64'(mem_write), 64'(0));
        check("reset_mem_read", 64'(mem_read), 64'(0));
        check("reset_rddata", 64'(cpu_uncached_rddata), 64'(0));
        check("reset_wbuf_empty", 64'(wbuf_empty), 64'(1));
        check("reset_stall", 64'(cpu_uncached_stall), 64'(1));
        #1 rst = 1'b0;

        // Phases: heavy back-pressure, free-running memory, mixed with resets.
        for (int phase = 0; phase < 3; phase++) begin
            p_stall = (phase == 0) ? 70 : (phase == 1) ? 0 : 30;
            p_req   = (phase == 0) ? 85 : (phase == 1) ? 60 : 70;
            p_rst   = (phase == 2) ? 2 : 0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                rst        = ($urandom_range(0, 99) < p_rst);
                mem_stall  = ($urandom_range(0, 99) < p_stall);
                mem_rddata = $urandom;
                if (!cpu_uncached_write && !cpu_uncached_read) new_request(p_req);
                #1;
                compare_cycle();
                model_step(done);
                @(posedge clk);
                #1;
                if (done) begin
                    cpu_uncached_write = 1'b0;
                    cpu_uncached_read  = 1'b0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
